// File: rtl/rob_pkg.sv
// Shared reorder-buffer configuration: sizing, instruction type codes and the
// per-entry record layout used by the ROB.
package rob_pkg;

  localparam int ROB_SIZE       = 8;
  localparam int ROB_SIZE_WIDTH = 3;
  // One extra bit so the occupancy count can represent a completely full buffer.
  localparam int COUNT_WIDTH    = ROB_SIZE_WIDTH + 1;

  // RISC-V major opcodes used as instruction type codes.
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] B_TYPE = 7'b1100011;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [6:0]  inst_type;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        pred_taken;
    logic [31:0] other_pc;
  } rob_entry_t;

  // A branch stores its resolved direction in value[0]; a mismatch with the
  // prediction means the front end fetched down the wrong path.
  function automatic logic is_mispredict(input logic [6:0]  inst_type,
                                         input logic [31:0] value,
                                         input logic        pred_taken);
    return (inst_type == B_TYPE) && (value[0] != pred_taken);
  endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order commit of out-of-order results, with operand
// bypass for the decoder and a one-cycle flush on branch misprediction.
module rob
  import rob_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      issue_valid,
  input  logic [6:0]                issue_type,
  input  logic [4:0]                issue_rd,
  input  logic                      issue_ready,
  input  logic [31:0]               issue_value,
  input  logic                      issue_pred_taken,
  input  logic [31:0]               issue_other_pc,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  input  logic [ROB_SIZE_WIDTH-1:0] query_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] query_id2,
  output logic                      query_ready1,
  output logic [31:0]               query_value1,
  output logic                      query_ready2,
  output logic [31:0]               query_value2,
  input  logic                      rs_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]               rs_value,
  input  logic                      lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]               lsb_value,
  output logic                      commit_valid,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic                      rob_clear,
  output logic [31:0]               rob_clear_pc
);

  rob_entry_t                entries [ROB_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] head;
  logic [ROB_SIZE_WIDTH-1:0] tail;
  logic [COUNT_WIDTH-1:0]    count;

  // Everything is frozen while stalled, and the flush cycle discards whatever
  // the rest of the pipeline still presents.
  logic active;
  logic rs_en;
  logic lsb_en;
  logic do_issue;
  logic do_commit;
  logic mispredict;

  rob_entry_t  head_entry;
  logic        head_ready;
  logic [31:0] head_value;
  logic        new_ready;
  logic [31:0] new_value;

  assign active      = rdy && !rob_clear;
  assign rs_en       = active && rs_ready;
  assign lsb_en      = active && lsb_ready;
  assign rob_full    = (count == COUNT_WIDTH'(ROB_SIZE));
  assign rob_tail_id = tail;
  assign do_issue    = active && issue_valid && !rob_full;
  assign head_entry  = entries[head];
  assign do_commit   = active && head_ready;
  assign mispredict  = do_commit &&
                       is_mispredict(head_entry.inst_type, head_value, head_entry.pred_taken);

  // Operand lookup for source 1: stored result first, then same-cycle broadcasts.
  always_comb begin
    query_ready1 = 1'b0;
    query_value1 = '0;
    if (entries[query_id1].busy && entries[query_id1].ready) begin
      query_ready1 = 1'b1;
      query_value1 = entries[query_id1].value;
    end else if (rs_en && rs_rob_id == query_id1) begin
      query_ready1 = 1'b1;
      query_value1 = rs_value;
    end else if (lsb_en && lsb_rob_id == query_id1) begin
      query_ready1 = 1'b1;
      query_value1 = lsb_value;
    end
  end

  // Operand lookup for source 2, same priority as source 1.
  always_comb begin
    query_ready2 = 1'b0;
    query_value2 = '0;
    if (entries[query_id2].busy && entries[query_id2].ready) begin
      query_ready2 = 1'b1;
      query_value2 = entries[query_id2].value;
    end else if (rs_en && rs_rob_id == query_id2) begin
      query_ready2 = 1'b1;
      query_value2 = rs_value;
    end else if (lsb_en && lsb_rob_id == query_id2) begin
      query_ready2 = 1'b1;
      query_value2 = lsb_value;
    end
  end

  // Head readiness includes a broadcast landing this cycle so it commits one edge sooner.
  always_comb begin
    head_ready = 1'b0;
    head_value = head_entry.value;
    if (head_entry.busy) begin
      if (head_entry.ready) begin
        head_ready = 1'b1;
      end else if (rs_en && rs_rob_id == head) begin
        head_ready = 1'b1;
        head_value = rs_value;
      end else if (lsb_en && lsb_rob_id == head) begin
        head_ready = 1'b1;
        head_value = lsb_value;
      end
    end
  end

  // A newly issued entry picks up a result broadcast aimed at its id this same cycle.
  always_comb begin
    new_ready = issue_ready;
    new_value = issue_value;
    if (rs_en && rs_rob_id == tail) begin
      new_ready = 1'b1;
      new_value = rs_value;
    end else if (lsb_en && lsb_rob_id == tail) begin
      new_ready = 1'b1;
      new_value = lsb_value;
    end
  end

  // Entry storage: broadcast writeback, allocation at tail, retirement at head, flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries[i] <= '0;
      end
    end else if (rdy) begin
      if (mispredict) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          entries[i].busy <= 1'b0;
        end
      end else begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          if (entries[i].busy && !entries[i].ready) begin
            if (rs_en && rs_rob_id == ROB_SIZE_WIDTH'(i)) begin
              entries[i].ready <= 1'b1;
              entries[i].value <= rs_value;
            end else if (lsb_en && lsb_rob_id == ROB_SIZE_WIDTH'(i)) begin
              entries[i].ready <= 1'b1;
              entries[i].value <= lsb_value;
            end
          end
        end
        if (do_issue) begin
          entries[tail] <= '{busy:       1'b1,
                             ready:      new_ready,
                             inst_type:  issue_type,
                             rd:         issue_rd,
                             value:      new_value,
                             pred_taken: issue_pred_taken,
                             other_pc:   issue_other_pc};
        end
        if (do_commit) begin
          entries[head].busy <= 1'b0;
        end
      end
    end
  end

  // Head/tail pointers and occupancy; a flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_issue) begin
          tail <= tail + 1'b1;
        end
        if (do_commit) begin
          head <= head + 1'b1;
        end
        case ({do_issue, do_commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Registered commit and flush outputs; the valid pulses drop while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid  <= 1'b0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_rob_id <= '0;
      rob_clear     <= 1'b0;
      rob_clear_pc  <= '0;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      rob_clear    <= 1'b0;
    end else begin
      commit_valid <= do_commit;
      rob_clear    <= mispredict;
      if (do_commit) begin
        commit_rd     <= mispredict ? 5'd0 : head_entry.rd;
        commit_value  <= head_value;
        commit_rob_id <= head;
      end
      if (mispredict) begin
        rob_clear_pc <= head_entry.other_pc;
      end
    end
  end

endmodule
